vec_dot_tx: RTL

VEC_DOT_TX -- requirements
Module: vec_dot_tx

---
 rtl/vec_pkg.sv | 27 ++
 rtl/uart_byte_sender.sv | 99 +++++++++
 rtl/vec_dot_tx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector dot-product transmitter and the B loader.
//
// Contents:
//   state_t  - control states for the dot-product / byte-transmit sequence
//   calc_rw  - bit width of an N-element, W-bit unsigned dot product
//   calc_nb  - number of bytes needed to carry a calc_rw-bit result
package vec_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAC     = 3'd1,
        LOAD    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Each product needs 2w bits. Summing n of them adds clog2(n) bits.
    function automatic int calc_rw(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

    function automatic int calc_nb(input int n, input int w);
        return (calc_rw(n, w) + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// Byte sequencer that pushes a multi-byte result into a UART transmitter,
// most significant byte first, using the transmitter's busy handshake.
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   send       - one-cycle request to start sending data (must arrive in IDLE)
//   data       - RW-bit value to send; held stable by the owner while sending
//   tx_busy    - transmitter busy flag
//   tx_start   - one-cycle launch pulse for tx_data
//   tx_data    - byte being launched, zero when tx_start is low
//   finished   - combinational pulse in the cycle the last byte completes
module uart_byte_sender
    import vec_pkg::*;
#(
    parameter int RW = 18,
    parameter int NB = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          send,
    input  logic [RW-1:0] data,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          finished
);

    localparam int PW = NB * 8;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] k;
    logic [KW-1:0] k_next;
    logic [PW-1:0] padded;

    // Zero-pad the result up to a whole number of bytes so byte k can be
    // taken with a plain shift.
    assign padded = PW'(data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    // tx_start is decoded from LOAD so it can only fire when the transmitter
    // is idle; the WAIT_HI state that always follows keeps it from firing on
    // two consecutive cycles. It is also suppressed during reset so an abort
    // cannot launch a byte in the reset cycle.
    always_comb begin
        state_next = state;
        k_next     = k;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        finished   = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    state_next = LOAD;
                    k_next     = KW'(NB - 1);
                end
            end
            LOAD: begin
                if (!tx_busy) begin
                    state_next = WAIT_HI;
                    if (!reset) begin
                        tx_start = 1'b1;
                        tx_data  = 8'(padded >> {k, 3'b000});
                    end
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (k != '0) begin
                        k_next     = k - KW'(1);
                        state_next = LOAD;
                    end else begin
                        finished   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/vec_dot_tx.sv
// Computes the unsigned dot product of two N-element vectors with one
// multiply-accumulate per cycle, then transmits the result over a UART
// byte interface, most significant byte first.
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - one-cycle request, accepted only in IDLE
//   A, B       - operand vectors, element i at [i]; snapshotted on start
//   tx_busy    - UART transmitter busy flag
//   tx_start   - one-cycle launch pulse for tx_data
//   tx_data    - byte to transmit, valid with tx_start
//   busy       - high while an accepted request is in progress
//   done       - one-cycle pulse after the last byte completes
//   result     - last computed dot product
module vec_dot_tx
    import vec_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int RW = calc_rw(N, W),
    localparam int NB = calc_nb(N, W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N-1:0][W-1:0] A,
    input  logic [N-1:0][W-1:0] B,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                busy,
    output logic                done,
    output logic [RW-1:0]       result
);

    localparam int IW = $clog2(N);

    state_t               state;
    state_t               state_next;
    logic [N-1:0][W-1:0]  a_q;
    logic [N-1:0][W-1:0]  b_q;
    logic [RW-1:0]        acc;
    logic [RW-1:0]        acc_sum;
    logic [2*W-1:0]       prod;
    logic [IW-1:0]        idx;
    logic                 last_mac;
    logic                 send;
    logic                 finished;

    // Operands are widened before multiplying so the full 2W-bit product
    // is kept; the accumulator has clog2(N) spare bits so it cannot wrap.
    assign prod     = {{W{1'b0}}, a_q[idx]} * {{W{1'b0}}, b_q[idx]};
    assign acc_sum  = acc + {{(RW - 2 * W){1'b0}}, prod};
    assign last_mac = (idx == IW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // While the sender walks its own LOAD/WAIT_HI/WAIT_LO sequence this
    // controller simply parks in LOAD until the sender reports the final byte.
    always_comb begin
        state_next = state;
        send       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (last_mac) begin
                    send       = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (finished) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = !reset;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Snapshotting A and B on start decouples the computation from later
    // changes by the upstream loader. result is written only on the final
    // MAC step, so it stays stable for the whole transmit phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            result <= '0;
        end else if (state == IDLE && start) begin
            a_q <= A;
            b_q <= B;
            acc <= '0;
            idx <= '0;
        end else if (state == MAC) begin
            acc <= acc_sum;
            idx <= idx + IW'(1);
            if (last_mac) begin
                result <= acc_sum;
            end
        end
    end

    uart_byte_sender #(
        .RW(RW),
        .NB(NB)
    ) u_sender (
        .clk      (clk),
        .reset    (reset),
        .send     (send),
        .data     (result),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .finished (finished)
    );

endmodule
